// File: rtl/kronos_mem_arb_pkg.sv
// Shared types for the kronos memory arbiter: access owner and per-port request bundle.
package kronos_types;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } mem_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        wr;
        logic        req;
    } mem_req_t;

endpackage

// File: rtl/kronos_mem_arb_prio.sv
// Per-cycle grant decision between fetch and load/store; data wins unless fairness
// (KRONOS_MEM_ARB_FAIR_EN) sees the fetch side denied STARVE_MAX cycles in a row.
module kronos_mem_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rstz,
    input  logic instr_req,
    input  logic data_req,
    output logic gnt_i,
    output logic gnt_d
);

`ifdef KRONOS_MEM_ARB_FAIR_EN
    logic [2:0] starve_cnt;
    logic       starved;

    assign starved = instr_req & (int'(starve_cnt) >= STARVE_MAX);
    assign gnt_i   = instr_req & (~data_req | starved);
    assign gnt_d   = data_req & ~starved;

    // Saturates at 7 so a large STARVE_MAX cannot wrap back to zero.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            starve_cnt <= '0;
        end else if (!instr_req || gnt_i) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 3'd7) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    localparam int unused_starve_max = STARVE_MAX;
    logic unused_fair;

    assign unused_fair = clk ^ rstz;
    assign gnt_i       = instr_req & ~data_req;
    assign gnt_d       = data_req;
`endif

endmodule

// File: rtl/kronos_mem_arb.sv
// Shares one single-port SRAM between fetch and load/store; ack + read data one cycle
// after grant. Denied requester gets no ack and must re-present. Fairness: KRONOS_MEM_ARB_FAIR_EN.
module kronos_mem_arb
    import kronos_types::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic [31:0]       instr_addr,
    input  logic              instr_req,
    output logic              instr_ack,
    output logic [31:0]       instr_data,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_mask,
    input  logic              data_wr,
    input  logic              data_req,
    output logic              data_ack,
    output logic [31:0]       data_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [3:0]        mem_mask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    mem_req_t   ireq;
    mem_req_t   dreq;
    mem_req_t   granted;
    mem_owner_t owner;
    logic       gnt_i;
    logic       gnt_d;

    // Fetch never writes, so its bundle carries zero write fields.
    assign ireq = '{addr: instr_addr, wdata: 32'd0, mask: 4'd0, wr: 1'b0, req: instr_req};
    assign dreq = '{addr: data_addr, wdata: data_wdata, mask: data_mask, wr: data_wr, req: data_req};

    kronos_mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk       (clk),
        .rstz      (rstz),
        .instr_req (ireq.req),
        .data_req  (dreq.req),
        .gnt_i     (gnt_i),
        .gnt_d     (gnt_d)
    );

    assign granted = gnt_d ? dreq : (gnt_i ? ireq : mem_req_t'('0));

    assign mem_en    = granted.req;
    assign mem_addr  = {granted.addr[ADDR_W-1:2], 2'b00};
    assign mem_wen   = granted.wr;
    assign mem_mask  = granted.wr ? granted.mask : 4'd0;
    assign mem_wdata = granted.wdata;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            owner <= NONE;
        end else if (gnt_d) begin
            owner <= DATA;
        end else if (gnt_i) begin
            owner <= INSTR;
        end else begin
            owner <= NONE;
        end
    end

    assign instr_ack  = (owner == INSTR);
    assign data_ack   = (owner == DATA);
    assign instr_data = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_kronos_mem_arb.sv
// Randomized and directed bench for kronos_mem_arb against a transaction-level model.
module tb_kronos_mem_arb;

`ifdef KRONOS_MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic        instr_ack;
    logic [31:0] instr_data;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mask;
    logic        data_wr;
    logic        data_req;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic [31:0] mem_addr;
    logic        mem_en;
    logic        mem_wen;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    kronos_mem_arb dut (
        .clk        (clk),
        .rstz       (rstz),
        .instr_addr (instr_addr),
        .instr_req  (instr_req),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_mask  (data_mask),
        .data_wr    (data_wr),
        .data_req   (data_req),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_mask   (mem_mask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // SRAM macro stand-in: 256 words, read data one cycle after enable.
    logic [31:0] sram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= sram[mem_addr[9:2]];
        end
    end

    // Reference model state: expected memory contents and the pending access.
    logic [31:0] ref_mem [256];
    int          exp_own;       // 0 none, 1 instr, 2 data
    logic        exp_wr;
    logic [31:0] exp_rd;
    int          starve;
    int          instr_ack_seen;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] wd, input logic [3:0] dm);
        logic        starved, gi, gd;
        logic [31:0] ga;
        int          idx;
        chk("instr_ack", instr_ack, exp_own == 1);
        chk("data_ack", data_ack, exp_own == 2);
        if (exp_own == 1) chk("instr_data", instr_data, exp_rd);
        if (exp_own == 2 && !exp_wr) chk("data_rdata", data_rdata, exp_rd);
        if (instr_ack) instr_ack_seen++;

        instr_req = ir; instr_addr = ia;
        data_req = dr; data_wr = dw; data_addr = da; data_wdata = wd; data_mask = dm;
        #1;

        starved = FAIR && ir && (starve >= STARVE);
        gd = dr && !starved;
        gi = ir && (!dr || starved);
        ga = gd ? da : ia;
        idx = int'(ga[9:2]);
        chk("mem_en", mem_en, gd || gi);
        if (gd || gi) chk("mem_addr", mem_addr, {ga[31:2], 2'b00});
        chk("mem_wen", mem_wen, gd && dw);
        chk("mem_mask", mem_mask, (gd && dw) ? dm : 4'd0);
        if (gd && dw) chk("mem_wdata", mem_wdata, wd);

        exp_wr = gd && dw;
        exp_own = gd ? 2 : (gi ? 1 : 0);
        exp_rd = ref_mem[idx];
        if (gd && dw)
            for (int b = 0; b < 4; b++)
                if (dm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        if (ir && !gi) starve = (starve < 7) ? starve + 1 : 7;
        else starve = 0;

        @(posedge clk); #1;
    endtask

    initial begin
        rstz = 1'b0;
        instr_req = 0; instr_addr = 0; data_req = 0; data_wr = 0;
        data_addr = 0; data_wdata = 0; data_mask = 0;
        exp_own = 0; exp_wr = 0; exp_rd = 0; starve = 0; instr_ack_seen = 0;
        for (int i = 0; i < 256; i++) begin
            sram[i] = $urandom;
            ref_mem[i] = sram[i];
        end
        @(posedge clk); #1;
        chk("reset_instr_ack", instr_ack, 1'b0);
        chk("reset_data_ack", data_ack, 1'b0);
        @(posedge clk); #1;
        rstz = 1'b1;

        // Instruction-only stream.
        cycle(1, 32'h0, 0, 0, 0, 0, 0);
        cycle(1, 32'h4, 0, 0, 0, 0, 0);
        cycle(1, 32'h8, 0, 0, 0, 0, 0);
        // Collision, then fetch re-presents.
        cycle(1, 32'h10, 1, 0, 32'h100, 0, 0);
        cycle(1, 32'h10, 0, 0, 0, 0, 0);
        // Masked store then load-back of the same word.
        cycle(0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 4'b0011);
        cycle(0, 0, 1, 0, 32'h20, 0, 0);
        // Idle, then an unaligned fetch.
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 32'h13, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Reset asserted while a fetch grant is in flight.
        instr_req = 1; instr_addr = 32'h40; #1;
        chk("rst_mid_mem_en", mem_en, 1'b1);
        rstz = 1'b0; #1;
        @(posedge clk); #1;
        chk("rst_mid_instr_ack", instr_ack, 1'b0);
        chk("rst_mid_data_ack", data_ack, 1'b0);
        rstz = 1'b1;
        exp_own = 0; starve = 0;
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Both requesters held for 20 cycles.
        instr_ack_seen = 0;
        for (int i = 0; i < 20; i++) cycle(1, 32'h80, 1, 0, 32'h200, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("held_instr_acks", instr_ack_seen, FAIR ? 32'd4 : 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1023), $urandom, 4'($urandom));
        cycle(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
